// File: rtl/xor_parity_seq.sv
// Bit-serial parity/popcount engine: one shared 2-input XOR reduces a latched
// word one bit per clock behind a start/busy/done handshake.

module xor_gate_struct (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module xor_parity_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             odd_sel,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             parity_out,
  output logic [CW-1:0]    ones_count
);
  localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic             acc_q;
  logic [CNTW-1:0]  cnt_q;
  logic [CW-1:0]    ones_q;
  logic             busy_q, done_q, par_q;
  logic [CW-1:0]    cnt_out_q;
  logic             y;

  // The only XOR in the parity path: accumulator folded with the next bit.
  xor_gate_struct u_xor (
    .a (acc_q),
    .b (shreg_q[0]),
    .y (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      ones_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      par_q     <= 1'b0;
      cnt_out_q <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q <= data_in;
            acc_q   <= odd_sel;
            cnt_q   <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= y;
          ones_q  <= ones_q + CW'(shreg_q[0]);
          shreg_q <= shreg_q >> 1;
          if (cnt_q == CNTW'(WIDTH-1)) begin
            par_q     <= y;
            cnt_out_q <= ones_q + CW'(shreg_q[0]);
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign parity_out = par_q;
  assign ones_count = cnt_out_q;

endmodule

// File: tb/tb_xor_parity_seq.sv
// Directed bench for xor_parity_seq: vector table of single words plus
// hand-built sequences for ignored start, back-to-back, clear and reset.

module tb_xor_parity_seq;
  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          odd_sel = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          busy, done, parity_out;
  logic [CW-1:0] ones_count;

  int total = 0;
  int bad   = 0;

  xor_parity_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .odd_sel    (odd_sel),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .parity_out (parity_out),
    .ones_count (ones_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic          o;
    logic          ep;
    logic [CW-1:0] ec;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_word(input vec_t v, input string nm);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1; data_in = v.d; odd_sel = v.o;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; data_in = '0; odd_sel = 1'b0;
    check({nm, " busy"}, busy, 1);
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) seen = 1;
    end
    check({nm, " latency"}, n, W);
    check({nm, " parity"}, parity_out, v.ep);
    check({nm, " ones"}, ones_count, v.ec);
    @(posedge clk);
    @(negedge clk);
    check({nm, " done_fall"}, done, 0);
    check({nm, " busy_fall"}, busy, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int ndone, cyc, nd;
    int dt[3];
    vec_t v;

    vecs[0] = '{8'hB7, 1'b0, 1'b0, 4'd6};
    vecs[1] = '{8'hB7, 1'b1, 1'b1, 4'd6};
    vecs[2] = '{8'h80, 1'b0, 1'b1, 4'd1};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 4'd0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 4'd8};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 4'd1};

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset parity", parity_out, 0);
    check("reset ones", ones_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_word(vecs[i], $sformatf("vec%0d", i));

    // start during RUN (edge 3) must be ignored
    @(negedge clk);
    start = 1'b1; data_in = 8'hB7; odd_sel = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0; data_in = '0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    start = 1'b1; data_in = 8'hFF;
    @(posedge clk); @(negedge clk);
    start = 1'b0; data_in = '0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (done) ndone++;
    end
    check("ignore ndone", ndone, 1);
    check("ignore parity", parity_out, 0);
    check("ignore ones", ones_count, 6);

    // start held high: one result every W+2 cycles
    @(negedge clk);
    start = 1'b1; data_in = 8'h80; odd_sel = 1'b0;
    nd = 0;
    for (int c = 0; c < 45 && nd < 3; c++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin dt[nd] = c; nd++; end
    end
    start = 1'b0; data_in = '0;
    check("held ndone", nd, 3);
    if (nd == 3) begin
      check("held period1", dt[1] - dt[0], W + 2);
      check("held period2", dt[2] - dt[1], W + 2);
    end
    check("held parity", parity_out, 1);
    check("held ones", ones_count, 1);
    for (int c = 0; c < 12; c++) @(negedge clk);
    check("held idle", busy, 0);

    // clear at edge 4 of a run
    start = 1'b1; data_in = 8'hB7;
    @(posedge clk); @(negedge clk);
    start = 1'b0; data_in = '0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); @(negedge clk); end
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    check("clear busy", busy, 0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (done) ndone++;
    end
    check("clear ndone", ndone, 0);
    check("clear parity kept", parity_out, 1);
    check("clear ones kept", ones_count, 1);

    // clear beats start in IDLE
    clear = 1'b1; start = 1'b1; data_in = 8'hFF;
    @(posedge clk); @(negedge clk);
    clear = 1'b0; start = 1'b0; data_in = '0;
    check("clear+start busy", busy, 0);
    @(posedge clk); @(negedge clk);
    check("clear+start stays idle", busy, 0);

    // async reset mid-run, then a clean run
    start = 1'b1; data_in = 8'hB7;
    @(posedge clk); @(negedge clk);
    start = 1'b0; data_in = '0;
    for (int c = 0; c < 5; c++) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst parity", parity_out, 0);
    check("midrst ones", ones_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{8'h01, 1'b0, 1'b1, 4'd1};
    run_word(v, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
